fifo_put_arbiter: RTL

- Shares the put side of one `fifo` instance among NUM_REQ independent writers.
- Uses a round-robin grant with a bounded burst: the current owner may write up to BURST_LEN consecutive words before the grant rotates.
- Sits between producer blocks and the FIFO; its fifo_* ports connect to the FIFO's put_io modport signals (full, data, wrreq).
- Consumers are untouched.

---
 rtl/fifo_put_arbiter_if.sv | 26 ++
 rtl/fifo_put_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fifo_put_arbiter_if.sv
// rtl/fifo_put_arbiter_if.sv - requester and FIFO put-side signal bundle for fifo_put_arbiter
interface fifo_put_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_full;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          fifo_wrreq;
    logic                          grant_valid;
    logic [GW-1:0]                 grant_id;

    modport master (
        input  req, req_data, fifo_full,
        output ack, fifo_data, fifo_wrreq, grant_valid, grant_id
    );

    modport slave (
        output req, req_data, fifo_full,
        input  ack, fifo_data, fifo_wrreq, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_put_arbiter.sv
// rtl/fifo_put_arbiter.sv - round-robin, burst-bounded arbiter sharing one FIFO put port
module fifo_put_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    fifo_put_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = ($clog2(BURST_LEN + 1) > 0) ? $clog2(BURST_LEN + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            write_en;

    // First set bit of mask at or after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [GW:0] pick(input logic [GW-1:0] ptr, input logic [NUM_REQ-1:0] mask);
        logic          found;
        logic [GW-1:0] sel;
        int            idx;
        found = 1'b0;
        sel   = '0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (mask[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
        return {found, sel};
    endfunction

    // Write strobe: owner has a word and the FIFO has room; suppressed while in reset.
    always_comb begin
        write_en = 1'b0;
        if (reset_n && (state_q == GRANT)) begin
            write_en = bus.req[grant_id_q] & ~bus.fifo_full;
        end
    end

    assign bus.fifo_wrreq  = write_en;
    assign bus.ack         = write_en ? (NUM_REQ'(1) << grant_id_q) : '0;
    assign bus.fifo_data   = write_en ? bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.grant_valid = reset_n && (state_q == GRANT);
    assign bus.grant_id    = reset_n ? grant_id_q : '0;

    // Next owner, burst progress and rotation pointer.
    always_comb begin
        logic              release_grant;
        logic [GW-1:0]     ptr_next;
        logic [NUM_REQ-1:0] masked;
        logic [GW:0]       pk;

        state_d       = state_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        release_grant = 1'b0;
        ptr_next      = '0;
        masked        = '0;
        pk            = '0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    pk          = pick(rr_ptr_q, bus.req);
                    state_d     = GRANT;
                    grant_id_d  = pk[GW-1:0];
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (write_en) begin
                    if (burst_cnt_q == CW'(BURST_LEN - 1)) begin
                        release_grant = 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (!bus.req[grant_id_q]) begin
                    release_grant = 1'b1;
                end

                // Hand over directly to the next requester; the outgoing owner is
                // masked so it cannot immediately win again.
                if (release_grant) begin
                    ptr_next    = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    rr_ptr_d    = ptr_next;
                    masked      = bus.req & ~(NUM_REQ'(1) << grant_id_q);
                    pk          = pick(ptr_next, masked);
                    burst_cnt_d = '0;
                    if (pk[GW]) begin
                        state_d    = GRANT;
                        grant_id_d = pk[GW-1:0];
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule
